// File: rtl/add_lane_sat.sv
// add_lane_sat: framed multi-lane saturating accumulator with sticky per-lane
// clamp flags, term count and protocol-error pulses.
module add_lane_sat #(
    parameter int IN_WIDTH  = 6,
    parameter int ACC_WIDTH = 8,
    parameter int LANES     = 4,
    parameter int MAX_TERMS = 8,
    localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic                       clk,
    input  logic                       xrst,
    input  logic                       i_val,
    input  logic                       i_first,
    input  logic                       i_last,
    input  logic [LANES*IN_WIDTH-1:0]  i_data,
    output logic [LANES*ACC_WIDTH-1:0] o_data,
    output logic                       o_val,
    output logic [LANES-1:0]           o_sat,
    output logic [CNT_W-1:0]           o_cnt,
    output logic                       o_err
);
    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                   state_q, state_d;
    logic [LANES*ACC_WIDTH-1:0] acc_q, acc_d, acc_new, o_data_q, o_data_d;
    logic [LANES-1:0]         sat_q, sat_d, sat_new, o_sat_q, o_sat_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_new, o_cnt_q, o_cnt_d;
    logic                     o_val_q, o_val_d, o_err_q, o_err_d;
    logic                     start;

    assign start   = i_val & i_first;
    assign cnt_new = start ? CNT_W'(1) : cnt_q + CNT_W'(1);

    // A frame start adds onto zero, so the first beat shares the clamp path.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [IN_WIDTH-1:0]  x;
        logic [ACC_WIDTH:0]   base, sum;
        logic                 ovf;
        assign x    = i_data[k*IN_WIDTH +: IN_WIDTH];
        assign base = start ? '0 : {acc_q[k*ACC_WIDTH+ACC_WIDTH-1], acc_q[k*ACC_WIDTH +: ACC_WIDTH]};
        assign sum  = base + {{(ACC_WIDTH+1-IN_WIDTH){x[IN_WIDTH-1]}}, x};
        assign ovf  = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        assign acc_new[k*ACC_WIDTH +: ACC_WIDTH] =
            ovf ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}} : sum[ACC_WIDTH-1:0];
        assign sat_new[k] = ovf | (~start & sat_q[k]);
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        sat_d    = sat_q;
        cnt_d    = cnt_q;
        o_data_d = o_data_q;
        o_sat_d  = o_sat_q;
        o_cnt_d  = o_cnt_q;
        o_val_d  = 1'b0;
        o_err_d  = 1'b0;
        if (i_val && (start || state_q == ACCUM)) begin
            acc_d   = acc_new;
            sat_d   = sat_new;
            cnt_d   = cnt_new;
            state_d = ACCUM;
            o_err_d = start && state_q == ACCUM;
            if (i_last || (!start && cnt_new == CNT_W'(MAX_TERMS))) begin
                state_d  = IDLE;
                o_val_d  = 1'b1;
                o_err_d  = o_err_d | ~i_last;
                o_data_d = acc_new;
                o_sat_d  = sat_new;
                o_cnt_d  = cnt_new;
            end
        end else if (i_val) begin
            o_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            sat_q    <= '0;
            cnt_q    <= '0;
            o_data_q <= '0;
            o_sat_q  <= '0;
            o_cnt_q  <= '0;
            o_val_q  <= 1'b0;
            o_err_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            sat_q    <= sat_d;
            cnt_q    <= cnt_d;
            o_data_q <= o_data_d;
            o_sat_q  <= o_sat_d;
            o_cnt_q  <= o_cnt_d;
            o_val_q  <= o_val_d;
            o_err_q  <= o_err_d;
        end
    end

    assign o_data = o_data_q;
    assign o_sat  = o_sat_q;
    assign o_cnt  = o_cnt_q;
    assign o_val  = o_val_q;
    assign o_err  = o_err_q;
endmodule

// File: tb/tb_add_lane_sat.sv
// tb_add_lane_sat: directed vectors with hand-computed results for add_lane_sat.
module tb_add_lane_sat;
    logic        clk = 1'b0;
    logic        xrst, i_val, i_first, i_last;
    logic [23:0] i_data;
    logic [31:0] o_data;
    logic        o_val, o_err;
    logic [3:0]  o_sat;
    logic [3:0]  o_cnt;
    int          checks = 0;
    int          failures = 0;

    add_lane_sat dut (
        .clk(clk), .xrst(xrst), .i_val(i_val), .i_first(i_first), .i_last(i_last),
        .i_data(i_data), .o_data(o_data), .o_val(o_val), .o_sat(o_sat),
        .o_cnt(o_cnt), .o_err(o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pk(int a, int b, int c, int d);
        return {d[5:0], c[5:0], b[5:0], a[5:0]};
    endfunction

    function automatic logic [31:0] od(int a, int b, int c, int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic step(input logic v, input logic f, input logic l, input logic [23:0] d);
        i_val = v;
        i_first = f;
        i_last = l;
        i_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        xrst = 1'b0;
        step(0, 0, 0, '0);
        step(1, 1, 1, pk(3, 3, 3, 3));
        chk("rst_data", o_data, 0);
        chk("rst_val", {31'd0, o_val}, 0);
        chk("rst_err", {31'd0, o_err}, 0);
        chk("rst_sat", {28'd0, o_sat}, 0);
        chk("rst_cnt", {28'd0, o_cnt}, 0);
        xrst = 1'b1;

        step(1, 1, 0, pk(10, 1, 1, 1));
        chk("t1_noval", {31'd0, o_val}, 0);
        step(1, 0, 0, pk(-3, 1, 1, 1));
        step(1, 0, 1, pk(20, 1, 1, 1));
        chk("t1_val", {31'd0, o_val}, 1);
        chk("t1_data", o_data, od(27, 3, 3, 3));
        chk("t1_cnt", {28'd0, o_cnt}, 3);
        chk("t1_sat", {28'd0, o_sat}, 0);
        chk("t1_err", {31'd0, o_err}, 0);

        step(1, 1, 0, pk(31, -32, 0, 0));
        chk("t2_noval", {31'd0, o_val}, 0);
        step(1, 0, 0, pk(31, -32, 0, 0));
        step(1, 0, 0, pk(31, -32, 0, 0));
        step(1, 0, 0, pk(31, -32, 0, 0));
        step(1, 0, 1, pk(31, -32, 0, 0));
        chk("t2_val", {31'd0, o_val}, 1);
        chk("t2_data", o_data, od(127, -128, 0, 0));
        chk("t2_sat", {28'd0, o_sat}, 4'b0011);
        chk("t2_cnt", {28'd0, o_cnt}, 5);

        step(1, 1, 1, pk(-5, 0, 0, 0));
        chk("t3_val", {31'd0, o_val}, 1);
        chk("t3_data", o_data, od(-5, 0, 0, 0));
        chk("t3_cnt", {28'd0, o_cnt}, 1);
        chk("t3_sat", {28'd0, o_sat}, 0);
        chk("t3_err", {31'd0, o_err}, 0);
        step(0, 1, 1, pk(9, 9, 9, 9));
        chk("t3_val_low", {31'd0, o_val}, 0);
        chk("t3_hold", o_data, od(-5, 0, 0, 0));
        chk("t3_ign_err", {31'd0, o_err}, 0);

        step(1, 1, 0, pk(7, 0, 0, 0));
        step(1, 0, 0, pk(7, 0, 0, 0));
        step(1, 1, 0, pk(1, 0, 0, 0));
        chk("t4_err", {31'd0, o_err}, 1);
        chk("t4_noval", {31'd0, o_val}, 0);
        step(1, 0, 1, pk(2, 0, 0, 0));
        chk("t4_val", {31'd0, o_val}, 1);
        chk("t4_data", o_data, od(3, 0, 0, 0));
        chk("t4_cnt", {28'd0, o_cnt}, 2);
        chk("t4_err_clr", {31'd0, o_err}, 0);

        step(1, 1, 0, pk(1, 0, 0, 0));
        for (int i = 0; i < 6; i++) step(1, 0, 0, pk(1, 0, 0, 0));
        chk("t5_pre_val", {31'd0, o_val}, 0);
        step(1, 0, 0, pk(1, 0, 0, 0));
        chk("t5_val", {31'd0, o_val}, 1);
        chk("t5_err", {31'd0, o_err}, 1);
        chk("t5_data", o_data, od(8, 0, 0, 0));
        chk("t5_cnt", {28'd0, o_cnt}, 8);
        step(1, 0, 0, pk(1, 0, 0, 0));
        chk("t5_idle_err", {31'd0, o_err}, 1);
        chk("t5_idle_noval", {31'd0, o_val}, 0);
        chk("t5_hold", o_data, od(8, 0, 0, 0));
        chk("t5_hold_cnt", {28'd0, o_cnt}, 8);

        step(1, 1, 0, pk(5, 0, 0, 0));
        step(1, 0, 0, pk(5, 0, 0, 0));
        xrst = 1'b0;
        step(0, 0, 0, '0);
        chk("t6_rst_data", o_data, 0);
        chk("t6_rst_cnt", {28'd0, o_cnt}, 0);
        chk("t6_rst_val", {31'd0, o_val}, 0);
        chk("t6_rst_err", {31'd0, o_err}, 0);
        xrst = 1'b1;
        step(1, 1, 0, pk(4, 0, 0, 0));
        chk("t6_no_err", {31'd0, o_err}, 0);
        chk("t6_noval", {31'd0, o_val}, 0);
        step(1, 0, 1, pk(4, 0, 0, 0));
        chk("t6_val", {31'd0, o_val}, 1);
        chk("t6_data", o_data, od(8, 0, 0, 0));
        chk("t6_cnt", {28'd0, o_cnt}, 2);
        step(0, 0, 0, '0);
        chk("t6_val_clr", {31'd0, o_val}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
